button_toggle_pulse: RTL and testbench
======================================

BUTTON_TOGGLE_PULSE -- requirements
Module: button_toggle_pulse

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 4, which sets the number of consecutive stable synchronized samples needed to accept a level change (legal range 2..255).
REQ-002 The module SHALL have parameter CNT_W, default 8, which sets the width of press_count.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
REQ-005 The module SHALL have port btn_in, input, 1 bit: raw, asynchronous, bouncy push-button level (1 = pressed).
REQ-006 The module SHALL have port t_pulse, output, 1 bit: single-cycle pulse per accepted press, which drives the T input of the downstream T flip-flop.
REQ-007 The module SHALL have port press_count, output, CNT_W bits: running count of accepted presses.
REQ-008 The module SHALL have port busy, output, 1 bit: high while a candidate level change is being qualified.

Function
REQ-009 btn_in SHALL pass through a two-flop synchronizer (s1, then s2), and the FSM SHALL observe only s2.
REQ-010 The FSM SHALL have exactly four states: IDLE (released, stable), PRESS_CHK, HELD (pressed, stable) and RELEASE_CHK.
REQ-011 In IDLE: s2=1 SHALL go to PRESS_CHK with the debounce counter cnt=0; s2=0 SHALL stay in IDLE.
REQ-012 In PRESS_CHK: s2=0 SHALL return to IDLE and clear cnt; s2=1 with cnt==DEBOUNCE_CYCLES-1 SHALL go to HELD; otherwise cnt SHALL increment.
REQ-013 In HELD: s2=0 SHALL go to RELEASE_CHK with cnt=0; s2=1 SHALL stay in HELD.
REQ-014 In RELEASE_CHK: s2=1 SHALL return to HELD and clear cnt; s2=0 with cnt==DEBOUNCE_CYCLES-1 SHALL go to IDLE; otherwise cnt SHALL increment.
REQ-015 t_pulse SHALL be a registered output, high for exactly one cycle, set on the same edge as the PRESS_CHK->HELD transition, and low on all other cycles.
REQ-016 Press latency: with the first rising edge that samples btn_in=1 counted as edge 1, t_pulse SHALL be high during the cycle after edge DEBOUNCE_CYCLES+3, provided btn_in stays 1 throughout.
REQ-017 Releases SHALL never generate t_pulse.
REQ-018 press_count SHALL increment by 1 on the same edge that sets t_pulse, and SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-019 busy SHALL be a registered output equal to 1 exactly while the state is PRESS_CHK or RELEASE_CHK.
REQ-020 Bounce rejection: any run of s2 shorter than DEBOUNCE_CYCLES samples at the new level SHALL return the FSM to its prior stable state, with no t_pulse and no press_count change.
REQ-021 cnt SHALL be ceil(log2(DEBOUNCE_CYCLES)) bits wide or wider, and SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-022 A button held indefinitely SHALL produce exactly one t_pulse, with no auto-repeat.

Reset
REQ-023 When reset=0 at a rising edge, the module SHALL set s1=0, s2=0, state=IDLE, cnt=0, t_pulse=0, press_count=0 and busy=0, regardless of current state.
REQ-024 reset SHALL take priority over every transition; a pulse due on the same edge SHALL be suppressed.
REQ-025 If btn_in is held at 1 across reset release, the module SHALL treat it as a new press after release and issue one t_pulse per REQ-016, counting from the first non-reset edge.
REQ-026 After reset release, press_count SHALL read 0 until the first accepted press.

Verification (clk period 10 ns, DEBOUNCE_CYCLES=4)
REQ-027 Clean press: reset=0 for 2 edges, then btn_in=1 held for 20 cycles -> exactly one t_pulse, high in the cycle after edge 7, and press_count=1.
REQ-028 Bounce: btn_in toggles 1,0,1,0 every cycle, then settles at 0 -> t_pulse stays 0, press_count=0, busy is seen high, and the FSM ends in IDLE.
REQ-029 Three clean press/release cycles (each 10 cycles high, 10 low) driving the downstream T flip-flop -> three t_pulses, press_count=3, and the flip-flop Q toggles 0->1->0->1.
REQ-030 Release bounce: btn_in held at 1 until HELD is reached, then a 0 for 2 cycles, then 1 again -> no second t_pulse and press_count unchanged.
REQ-031 Reset mid-qualification: assert reset=0 while busy=1 in PRESS_CHK -> next edge gives all outputs 0; with btn_in still 1 after release, t_pulse arrives DEBOUNCE_CYCLES+3 edges later.
REQ-032 Wrap: with CNT_W=2, apply 5 accepted presses -> press_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/button_toggle_pulse.sv
// button_toggle_pulse: synchronizes and debounces a raw push-button, then
// emits one registered t_pulse per accepted press to drive a downstream
// T flip-flop. Releases are debounced as well but never pulse.
//
// Output handshake: t_pulse is a single-cycle strobe with no ready/ack.
// The receiver must sample it on every rising edge of clk. press_count and
// busy are plain registered levels.
//
// Timing: btn_in passes through s1 and s2 before the FSM sees it. The FSM
// needs one edge to leave IDLE and DEBOUNCE_CYCLES more to accept, so a
// clean press pulses in the cycle after edge DEBOUNCE_CYCLES+3.
module button_toggle_pulse #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_in,
  output logic             t_pulse,
  output logic [CNT_W-1:0] press_count,
  output logic             busy
);

  localparam int CB = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CB-1:0] CNT_LAST = CB'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  logic          s1;
  logic          s2;
  state_t        state;
  logic [CB-1:0] cnt;

  // Synchronizer, debounce FSM and registered outputs. busy is driven from
  // the next-state decision so it always matches the qualifying states.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      t_pulse     <= 1'b0;
      press_count <= '0;
      busy        <= 1'b0;
    end else begin
      s1      <= btn_in;
      s2      <= s1;
      t_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (s2) begin
            state <= PRESS_CHK;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        PRESS_CHK: begin
          if (!s2) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            // Press accepted: pulse and count on the same edge as entering HELD.
            state       <= HELD;
            cnt         <= '0;
            busy        <= 1'b0;
            t_pulse     <= 1'b1;
            press_count <= press_count + 1'b1;
          end else begin
            cnt  <= cnt + 1'b1;
            busy <= 1'b1;
          end
        end
        HELD: begin
          if (!s2) begin
            state <= RELEASE_CHK;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        RELEASE_CHK: begin
          if (s2) begin
            state <= HELD;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            // Release accepted silently; releases never pulse.
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt  <= cnt + 1'b1;
            busy <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_toggle_pulse.sv
// Bench for button_toggle_pulse: directed scenarios plus random button
// activity, checked every cycle against a run-length debounce model.
module tb_button_toggle_pulse;

  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_in = 1'b0;
  always #5 clk = ~clk;

  logic       t_pulse, busy;
  logic [7:0] press_count;
  logic       w_pulse, w_busy;
  logic [1:0] w_count;

  button_toggle_pulse #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .t_pulse(t_pulse), .press_count(press_count), .busy(busy)
  );

  button_toggle_pulse #(.DEBOUNCE_CYCLES(D), .CNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .t_pulse(w_pulse), .press_count(w_count), .busy(w_busy)
  );

  // Downstream T flip-flop driven by t_pulse.
  logic q;
  always @(posedge clk) begin
    if (!reset) q <= 1'b0;
    else if (t_pulse) q <= ~q;
  end

  // ---------------- scoreboard counters ----------------
  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The button is seen two edges late. A level is accepted once the
  // synchronized signal has differed from the current stable level for
  // D+1 consecutive samples (one to notice, D to qualify).
  logic m_valid = 1'b0;
  logic m_d1 = 1'b0, m_d2 = 1'b0;
  logic m_stable = 1'b0;
  int   m_run = 0;
  logic m_pulse = 1'b0;
  logic m_busy = 1'b0;
  int   m_count = 0;

  always @(posedge clk) begin
    int   run_n;
    logic st_n;
    logic pl_n;
    int   cnt_n;
    if (!reset) begin
      m_valid  <= 1'b1;
      m_d1     <= 1'b0;
      m_d2     <= 1'b0;
      m_stable <= 1'b0;
      m_run    <= 0;
      m_pulse  <= 1'b0;
      m_busy   <= 1'b0;
      m_count  <= 0;
    end else begin
      run_n = m_run;
      st_n  = m_stable;
      pl_n  = 1'b0;
      cnt_n = m_count;
      if (m_d2 != m_stable) begin
        run_n = m_run + 1;
        if (run_n == D + 1) begin
          st_n  = m_d2;
          run_n = 0;
          if (m_d2) begin
            pl_n  = 1'b1;
            cnt_n = m_count + 1;
          end
        end
      end else begin
        run_n = 0;
      end
      m_run    <= run_n;
      m_stable <= st_n;
      m_pulse  <= pl_n;
      m_count  <= cnt_n;
      m_busy   <= (run_n > 0);
      m_d2     <= m_d1;
      m_d1     <= btn_in;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("t_pulse",       int'(t_pulse),     int'(m_pulse));
      chk("busy",          int'(busy),        int'(m_busy));
      chk("press_count",   int'(press_count), m_count % 256);
      chk("w_t_pulse",     int'(w_pulse),     int'(m_pulse));
      chk("w_busy",        int'(w_busy),      int'(m_busy));
      chk("w_press_count", int'(w_count),     m_count % 4);
    end
  end

  // ---------------- driver ----------------
  int tick_no = 0;
  int first_pulse = 0;
  int pulses = 0;
  int busy_seen = 0;
  int wlog[$];

  task automatic tick(input logic r, input logic b);
    reset  = r;
    btn_in = b;
    @(posedge clk);
    #1;
    tick_no++;
    if (t_pulse) begin
      pulses++;
      if (first_pulse == 0) first_pulse = tick_no;
    end
    if (w_pulse) wlog.push_back(int'(w_count));
    if (busy) busy_seen = 1;
  endtask

  task automatic clear_marks();
    tick_no = 0;
    first_pulse = 0;
    pulses = 0;
    busy_seen = 0;
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    clear_marks();
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) tick(1'b1, b);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len;
    logic lvl;

    // Reset state
    do_reset();
    chk("rst_t_pulse", int'(t_pulse), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(press_count), 0);
    chk("rst_w_count", int'(w_count), 0);

    // Clean press: pulse after edge 7, exactly one pulse
    hold(1'b1, 20);
    chk("clean_latency", first_pulse, 7);
    chk("clean_pulses", pulses, 1);
    chk("clean_count", int'(press_count), 1);
    chk("model_count_pin", m_count, 1);
    hold(1'b0, 10);
    chk("release_no_pulse", pulses, 1);
    chk("release_idle_busy", int'(busy), 0);

    // Bounce then settle low
    do_reset();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    hold(1'b0, 10);
    chk("bounce_pulses", pulses, 0);
    chk("bounce_count", int'(press_count), 0);
    chk("bounce_busy_seen", busy_seen, 1);
    chk("bounce_end_busy", int'(busy), 0);
    chk("model_stable_pin", int'(m_stable), 0);

    // Three press/release cycles into the T flip-flop
    do_reset();
    chk("tff_q0", int'(q), 0);
    hold(1'b1, 10); hold(1'b0, 10);
    chk("tff_q1", int'(q), 1);
    hold(1'b1, 10); hold(1'b0, 10);
    chk("tff_q2", int'(q), 0);
    hold(1'b1, 10); hold(1'b0, 10);
    chk("tff_q3", int'(q), 1);
    chk("three_pulses", pulses, 3);
    chk("three_count", int'(press_count), 3);

    // Release bounce while held
    do_reset();
    hold(1'b1, 10);
    hold(1'b0, 2);
    hold(1'b1, 10);
    chk("relbounce_pulses", pulses, 1);
    chk("relbounce_count", int'(press_count), 1);

    // Reset in the middle of press qualification
    hold(1'b0, 10);
    hold(1'b1, 4);
    chk("midq_busy", int'(busy), 1);
    tick(1'b0, 1'b1);
    chk("midq_rst_pulse", int'(t_pulse), 0);
    chk("midq_rst_busy", int'(busy), 0);
    chk("midq_rst_count", int'(press_count), 0);
    clear_marks();
    hold(1'b1, 12);
    chk("midq_latency", first_pulse, 7);
    chk("midq_pulses", pulses, 1);

    // Wrap of a 2-bit press counter
    do_reset();
    wlog.delete();
    for (int p = 0; p < 5; p++) begin
      hold(1'b1, 10);
      hold(1'b0, 10);
    end
    chk("wrap_len", wlog.size(), 5);
    if (wlog.size() == 5) begin
      chk("wrap_0", wlog[0], 1);
      chk("wrap_1", wlog[1], 2);
      chk("wrap_2", wlog[2], 3);
      chk("wrap_3", wlog[3], 0);
      chk("wrap_4", wlog[4], 1);
    end
    chk("wrap_wide_count", int'(press_count), 5);

    // Random button activity with occasional resets
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        tick(1'b0, 1'($urandom_range(0, 1)));
      end else begin
        lvl = 1'($urandom_range(0, 1));
        len = $urandom_range(1, 10);
        hold(lvl, len);
      end
    end
    hold(1'b0, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
